// File: rtl/cr_ob_frame_mon_pkg.sv
// Shared types and helpers for the cr_ob_frame_mon outbound stream monitor.
// Stats counters are built only when CR_OB_FRAME_MON_STATS_EN is defined.
package cr_ob_frame_mon_pkg;

  localparam logic [1:0] TUSER_SOT = 2'b01;
  localparam logic [1:0] TUSER_EOT = 2'b10;
  localparam logic [1:0] TUSER_MID = 2'b11;

  localparam logic [7:0] FT_CQE   = 8'h09;
  localparam logic [7:0] FT_STATS = 8'h08;

  localparam int MAX_STRB_W = 128;

  typedef enum logic {
    ST_IDLE,
    ST_IN_FRAME
  } fsm_state_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_SOT_IN_FRAME = 3'd1,
    ERR_NO_SOT       = 3'd2,
    ERR_TLAST        = 3'd3,
    ERR_STRB         = 3'd4,
    ERR_BYTES_SAT    = 3'd5
  } err_code_e;

  function automatic logic [15:0] popcount(
    input logic [MAX_STRB_W-1:0] v
  );
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

  // Legal strobe: non-zero, low bits contiguous (2^n - 1)
  function automatic logic strb_contig(
    input logic [MAX_STRB_W-1:0] v
  );
    logic [MAX_STRB_W-1:0] vp1;
    vp1 = v + 1'b1;
    return (v != '0) && ((v & vp1) == '0);
  endfunction

endpackage

// File: rtl/cr_axis_skid_buf.sv
// Two-entry register slice; ready depends only on its own occupancy.
// Output payload comes straight from the storage flops.
module cr_axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  assign push    = s_valid & rdy_q;
  assign pop     = (cnt_q != 2'd0) & m_ready;
  assign s_ready = rdy_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: rtl/cr_ob_frame_mon.sv
// Outbound AXI-stream monitor: skid slice, SoT/EoT framing, error checks.
// Define CR_OB_FRAME_MON_STATS_EN to build the saturating stats counters.
module cr_ob_frame_mon
  import cr_ob_frame_mon_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8,
  parameter int USER_W = 8,
  parameter int TID_W  = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [STRB_W-1:0] s_tstrb,
  input  logic [USER_W-1:0] s_tuser,
  input  logic [TID_W-1:0]  s_tid,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [STRB_W-1:0] m_tstrb,
  output logic [USER_W-1:0] m_tuser,
  output logic [TID_W-1:0]  m_tid,
  output logic              m_tlast,
  output logic              frame_done,
  output logic [7:0]        frame_type,
  output logic [15:0]       frame_bytes,
  output logic              err_pulse,
  output logic [2:0]        err_code,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_frames,
  output logic [CNT_W-1:0]  cnt_bytes,
  output logic [CNT_W-1:0]  cnt_errors
);

  localparam int SKID_W = DATA_W + STRB_W + USER_W + TID_W + 1;

  logic [SKID_W-1:0] skid_m_data;

  cr_axis_skid_buf #(
    .W (SKID_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_tvalid),
    .s_ready (s_tready),
    .s_data  ({s_tdata, s_tstrb, s_tuser, s_tid, s_tlast}),
    .m_valid (m_tvalid),
    .m_ready (m_tready),
    .m_data  (skid_m_data)
  );

  assign {m_tdata, m_tstrb, m_tuser, m_tid, m_tlast} = skid_m_data;

  fsm_state_e state_q, state_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] acc_q, acc_d;
  logic        sat_q, sat_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_type_q, frame_type_d;
  logic [15:0] frame_bytes_q, frame_bytes_d;
  logic        err_pulse_q, err_pulse_d;
  err_code_e   err_code_q, err_code_d;
  logic        cnt_beat;

  logic                  acc;
  logic [MAX_STRB_W-1:0] strb_ext;
  logic [15:0]           beat_bytes;
  logic [16:0]           sum;
  logic [15:0]           sum_sat;
  logic                  is_sot, is_eot, in_frame;
  logic                  e1, e2, e3, e4, e5;

  assign acc        = s_tvalid & s_tready;
  assign strb_ext   = MAX_STRB_W'(s_tstrb);
  assign beat_bytes = popcount(strb_ext);
  assign sum        = {1'b0, acc_q} + {1'b0, beat_bytes};
  assign sum_sat    = sum[16] ? 16'hFFFF : sum[15:0];
  assign is_sot     = (s_tuser[1:0] == TUSER_SOT);
  assign is_eot     = (s_tuser[1:0] == TUSER_EOT);
  assign in_frame   = (state_q == ST_IN_FRAME);

  assign e1 = is_sot & in_frame;
  assign e2 = !is_sot & !in_frame;
  assign e3 = s_tlast != (is_eot & in_frame & (type_q == FT_CQE));
  assign e4 = !strb_contig(strb_ext);
  assign e5 = !is_sot & in_frame & sum[16] & !sat_q;

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    acc_d         = acc_q;
    sat_d         = sat_q;
    frame_done_d  = 1'b0;
    frame_type_d  = frame_type_q;
    frame_bytes_d = frame_bytes_q;
    err_pulse_d   = 1'b0;
    err_code_d    = err_code_q;
    cnt_beat      = 1'b0;
    if (acc) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_sot) begin
            state_d  = ST_IN_FRAME;
            type_d   = s_tdata[7:0];
            acc_d    = beat_bytes;
            sat_d    = 1'b0;
            cnt_beat = 1'b1;
          end
        end
        ST_IN_FRAME: begin
          cnt_beat = 1'b1;
          if (is_sot) begin
            frame_done_d  = 1'b1;
            frame_type_d  = type_q;
            frame_bytes_d = acc_q;
            type_d        = s_tdata[7:0];
            acc_d         = beat_bytes;
            sat_d         = 1'b0;
          end else begin
            acc_d = sum_sat;
            sat_d = sat_q | sum[16];
            if (is_eot) begin
              frame_done_d  = 1'b1;
              frame_type_d  = type_q;
              frame_bytes_d = sum_sat;
              state_d       = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Several checks can hit one beat; the lowest code is reported
      err_pulse_d = e1 | e2 | e3 | e4 | e5;
      if (e1)      err_code_d = ERR_SOT_IN_FRAME;
      else if (e2) err_code_d = ERR_NO_SOT;
      else if (e3) err_code_d = ERR_TLAST;
      else if (e4) err_code_d = ERR_STRB;
      else if (e5) err_code_d = ERR_BYTES_SAT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      type_q        <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_type_q  <= '0;
      frame_bytes_q <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      frame_done_q  <= frame_done_d;
      frame_type_q  <= frame_type_d;
      frame_bytes_q <= frame_bytes_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_type  = frame_type_q;
  assign frame_bytes = frame_bytes_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;

`ifdef CR_OB_FRAME_MON_STATS_EN
  localparam int SW = CNT_W + 17;

  logic [CNT_W-1:0] cnt_frames_q, cnt_frames_d;
  logic [CNT_W-1:0] cnt_bytes_q, cnt_bytes_d;
  logic [CNT_W-1:0] cnt_errors_q, cnt_errors_d;
  logic [SW-1:0]    bsum;

  assign bsum = SW'(cnt_bytes_q) + SW'(beat_bytes);

  always_comb begin
    cnt_frames_d = cnt_frames_q;
    cnt_bytes_d  = cnt_bytes_q;
    cnt_errors_d = cnt_errors_q;
    if (clr_cnt) begin
      cnt_frames_d = '0;
      cnt_bytes_d  = '0;
      cnt_errors_d = '0;
    end else begin
      if (frame_done_d && (cnt_frames_q != '1)) begin
        cnt_frames_d = cnt_frames_q + 1'b1;
      end
      if (err_pulse_d && (cnt_errors_q != '1)) begin
        cnt_errors_d = cnt_errors_q + 1'b1;
      end
      if (cnt_beat) begin
        cnt_bytes_d = (bsum > SW'({CNT_W{1'b1}})) ?
                      '1 : bsum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_frames_q <= '0;
      cnt_bytes_q  <= '0;
      cnt_errors_q <= '0;
    end else begin
      cnt_frames_q <= cnt_frames_d;
      cnt_bytes_q  <= cnt_bytes_d;
      cnt_errors_q <= cnt_errors_d;
    end
  end

  assign cnt_frames = cnt_frames_q;
  assign cnt_bytes  = cnt_bytes_q;
  assign cnt_errors = cnt_errors_q;
`else
  logic unused_stats;
  assign unused_stats = clr_cnt ^ cnt_beat;
  assign cnt_frames   = '0;
  assign cnt_bytes    = '0;
  assign cnt_errors   = '0;
`endif

endmodule
